// File: rtl/crc_serial_pkg.sv
// Shared types and constants for the bit-serial CRC engine.
// Holds the FSM state enum, named polynomials and default INIT/XOROUT values.
package crc_serial_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam logic [7:0]  CRC8_SMBUS   = 8'h07;
    localparam logic [15:0] CRC16_CCITT  = 16'h1021;

    localparam logic [7:0]  CRC_INIT_DEF   = 8'h00;
    localparam logic [7:0]  CRC_XOROUT_DEF = 8'h00;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit LFSR step: folds a single data bit into a CRC register value.
// Ports: crc_i (current CRC), data_i (serial bit), poly_i (generator), crc_o (next CRC).
module crc_lfsr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] crc_i,
    input  logic             data_i,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] crc_o
);

    logic fb;

    assign fb    = crc_i[WIDTH-1] ^ data_i;
    assign crc_o = {crc_i[WIDTH-2:0], 1'b0} ^ (poly_i & {WIDTH{fb}});

endmodule

// File: rtl/crc_serial_x1.sv
// Bit-serial CRC engine with framed valid/ready input and result handshake.
// Ports: clk, nrst; s_valid/s_ready/s_data/s_last in; abort; m_valid/m_ready/m_crc/m_len out.
module crc_serial_x1
    import crc_serial_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(CRC8_SMBUS),
    parameter logic [WIDTH-1:0] INIT   = WIDTH'(CRC_INIT_DEF),
    parameter logic [WIDTH-1:0] XOROUT = WIDTH'(CRC_XOROUT_DEF),
    parameter int               CNT_W  = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             s_last,
    input  logic             abort,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_crc,
    output logic [CNT_W-1:0] m_len
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] crc_step;

    crc_lfsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (s_data),
        .poly_i (POLY),
        .crc_o  (crc_step)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ACCUM;
            crc_q   <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACCUM: begin
                if (s_valid) begin
                    crc_d = crc_step;
                    // Length sticks at all-ones on long frames.
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (s_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_d = ACCUM;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
        // Discard wins over any bit accept or result delivery.
        if (abort) begin
            state_d = ACCUM;
            crc_d   = INIT;
            cnt_d   = '0;
        end
    end

    assign s_ready = (state_q == ACCUM);
    assign m_valid = (state_q == DONE);
    assign m_crc   = crc_q ^ XOROUT;
    assign m_len   = cnt_q;

endmodule
